mul: RTL and testbench

MUL -- requirements
Module: mul

---
 rtl/mul.sv | 78 +++++++
 tb/tb_mul.sv | 117 +++++++++++
 2 files changed

// File: rtl/mul.sv
// mul: 32x32 shift-add multiplier (signed/unsigned) with cancel, 64-bit registered product.
// Optional macro MUL_EARLY_EXIT_EN finishes as soon as the remaining multiplier is zero.
module mul (
    input  logic        CLK,
    input  logic        RST,
    input  logic        SIGNED_MUL,
    input  logic        MUL_START,
    input  logic        MUL_CANCEL,
    input  logic [31:0] MULTIPLICAND,
    input  logic [31:0] MULTIPLIER,
    output logic        MUL_READY,
    output logic [63:0] MUL_RESULT
);
    typedef enum logic [1:0] {IDLE, ON, DONE} state_t;
    state_t      state;
    logic [63:0] mcand, acc;
    logic [31:0] mpl, mag_a, mag_b;
    logic [5:0]  cnt;
    logic        sign, fin;
    always_comb begin
        mag_a = (SIGNED_MUL && MULTIPLICAND[31]) ? -MULTIPLICAND : MULTIPLICAND;
        mag_b = (SIGNED_MUL && MULTIPLIER[31]) ? -MULTIPLIER : MULTIPLIER;
`ifdef MUL_EARLY_EXIT_EN
        fin = cnt[5] || (mpl == '0);
`else
        fin = cnt[5];
`endif
    end
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state      <= IDLE;
            MUL_READY  <= 1'b0;
            MUL_RESULT <= '0;
            mcand      <= '0;
            acc        <= '0;
            mpl        <= '0;
            cnt        <= '0;
            sign       <= 1'b0;
        end else if (MUL_CANCEL) begin
            state     <= IDLE;
            MUL_READY <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    MUL_READY <= 1'b0;
                    if (MUL_START) begin
                        mcand <= {32'd0, mag_a};
                        mpl   <= mag_b;
                        sign  <= SIGNED_MUL & (MULTIPLICAND[31] ^ MULTIPLIER[31]);
                        acc   <= '0;
                        cnt   <= '0;
                        state <= ON;
                    end
                end
                ON: begin
                    if (fin) begin
                        MUL_RESULT <= sign ? -acc : acc;
                        MUL_READY  <= 1'b1;
                        state      <= DONE;
                    end else begin
                        if (mpl[0]) acc <= acc + mcand;
                        mcand <= mcand << 1;
                        mpl   <= mpl >> 1;
                        cnt   <= cnt + 6'd1;
                    end
                end
                DONE: begin
                    MUL_READY <= 1'b0;
                    state     <= IDLE;
                end
                default: begin
                    MUL_READY <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mul.sv
// tb_mul: directed self-checking bench for mul (latency, products, cancel, reset, back-to-back).
module tb_mul;
    logic        CLK = 0, RST = 0, SIGNED_MUL = 0, MUL_START = 0, MUL_CANCEL = 0;
    logic [31:0] MULTIPLICAND = 0, MULTIPLIER = 0;
    logic        MUL_READY;
    logic [63:0] MUL_RESULT;
    logic [63:0] last = 0;
    int          checks = 0, errors = 0, seen = 0;
`ifdef MUL_EARLY_EXIT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    mul dut (
        .CLK(CLK), .RST(RST), .SIGNED_MUL(SIGNED_MUL), .MUL_START(MUL_START),
        .MUL_CANCEL(MUL_CANCEL), .MULTIPLICAND(MULTIPLICAND), .MULTIPLIER(MULTIPLIER),
        .MUL_READY(MUL_READY), .MUL_RESULT(MUL_RESULT)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Early-exit build: one cycle per multiplier bit up to its MSB, plus the write cycle.
    function automatic int exp_lat(input logic s, input logic [31:0] b);
        logic [31:0] m;
        int l;
        m = (s && b[31]) ? -b : b;
        l = 1;
        for (int i = 0; i < 32; i++) if (m[i]) l = i + 2;
        return EARLY ? l : 33;
    endfunction

    task automatic op(input string tag, input logic s, input logic [31:0] a, input logic [31:0] b,
                      input logic [63:0] exp);
        int n;
        n = 0;
        @(negedge CLK);
        chk({tag, "_idle_ready"}, {63'd0, MUL_READY}, 64'd0);
        SIGNED_MUL = s; MULTIPLICAND = a; MULTIPLIER = b; MUL_START = 1;
        do begin
            @(negedge CLK);
            n++;
            if (n == 3) begin
                MULTIPLICAND = $urandom; MULTIPLIER = $urandom; SIGNED_MUL = ~s;
            end
        end while (!MUL_READY && n < 60);
        MUL_START = 0;
        chk({tag, "_latency"}, 64'(n - 1), 64'(exp_lat(s, b)));
        chk({tag, "_result"}, MUL_RESULT, exp);
        last = exp;
    endtask

    initial begin
        #12;
        chk("reset_ready", {63'd0, MUL_READY}, 64'd0);
        chk("reset_result", MUL_RESULT, 64'd0);
        @(negedge CLK);
        RST = 1;
        op("u_ff_ff", 0, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001);
        op("s_m3x7", 1, 32'hFFFFFFFD, 32'd7, 64'hFFFFFFFF_FFFFFFEB);
        op("s_min_min", 1, 32'h80000000, 32'h80000000, 64'h40000000_00000000);
        op("b2b_2x3", 1, 32'd2, 32'd3, 64'd6);
        op("b2b_m1xm1", 1, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'd1);
        op("u_12345x1", 0, 32'd12345, 32'd1, 64'd12345);
        op("u_2xmsb", 0, 32'd2, 32'h80000000, 64'h00000001_00000000);
        op("s_zero", 1, 32'hFFFFFFFF, 32'd0, 64'd0);
        op("s_m1xmin", 1, 32'hFFFFFFFF, 32'h80000000, 64'h00000000_80000000);
        op("s_max_m1", 1, 32'h7FFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFF_80000001);
        op("u_min_min", 0, 32'h80000000, 32'h80000000, 64'h40000000_00000000);
        // Cancel mid-operation while START stays high: cancel must win.
        @(negedge CLK);
        SIGNED_MUL = 0; MULTIPLICAND = 5; MULTIPLIER = 6; MUL_START = 1;
        repeat (10) @(negedge CLK);
        MUL_CANCEL = 1;
        @(negedge CLK);
        chk("cancel_ready", {63'd0, MUL_READY}, 64'd0);
        chk("cancel_result", MUL_RESULT, last);
        MUL_CANCEL = 0; MUL_START = 0; seen = 0;
        repeat (40) begin
            @(negedge CLK);
            if (MUL_READY) seen++;
        end
        chk("cancel_no_ready", 64'(seen), 64'd0);
        chk("cancel_hold", MUL_RESULT, last);
        op("restart_5x6", 0, 32'd5, 32'd6, 64'd30);
        // Asynchronous reset in the middle of an operation.
        @(negedge CLK);
        SIGNED_MUL = 0; MULTIPLICAND = 7; MULTIPLIER = 9; MUL_START = 1;
        repeat (15) @(negedge CLK);
        MUL_START = 0;
        #2 RST = 0;
        #1;
        chk("arst_ready", {63'd0, MUL_READY}, 64'd0);
        chk("arst_result", MUL_RESULT, 64'd0);
        @(negedge CLK);
        RST = 1; seen = 0;
        repeat (40) begin
            @(negedge CLK);
            if (MUL_READY) seen++;
        end
        chk("arst_no_ready", 64'(seen), 64'd0);
        op("post_rst_7x9", 0, 32'd7, 32'd9, 64'd63);
        @(negedge CLK);
        chk("final_ready_low", {63'd0, MUL_READY}, 64'd0);
        chk("final_hold", MUL_RESULT, 64'd63);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
